// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent 50% duty outputs,
// each with a shadowed half-period that is only applied at a period boundary.
module clk_divider_multi #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEFAULT_HALF = 100_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [3:0]        wr_ch,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [NUM_CH-1:0] divided_clk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [WIDTH-1:0] DefaultHalf = WIDTH'(DEFAULT_HALF);
    localparam logic [WIDTH-1:0] One         = WIDTH'(1);

    logic [WIDTH-1:0]  cnt_q    [NUM_CH];
    logic [WIDTH-1:0]  cnt_d    [NUM_CH];
    logic [WIDTH-1:0]  half_q   [NUM_CH];
    logic [WIDTH-1:0]  half_d   [NUM_CH];
    logic [WIDTH-1:0]  shadow_q [NUM_CH];
    logic [WIDTH-1:0]  shadow_d [NUM_CH];
    logic [NUM_CH-1:0] out_q, out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] wrap;
    logic              wr_hit;

    assign wr_hit = wr_en && (32'(wr_ch) < NUM_CH);

    // A half value of 0 behaves as 1, so both wrap when the count is 0.
    always_comb begin
        wrap = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (half_q[i] == '0) begin
                wrap[i] = (cnt_q[i] == '0);
            end else begin
                wrap[i] = (cnt_q[i] == half_q[i] - One);
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        half_d   = half_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        tick_d   = tick_q;
        pend_d   = pend_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!en[i]) begin
                cnt_d[i]  = '0;
                out_d[i]  = 1'b0;
                tick_d[i] = 1'b0;
                half_d[i] = shadow_q[i];
                pend_d[i] = 1'b0;
            end else if (wrap[i]) begin
                cnt_d[i]  = '0;
                out_d[i]  = ~out_q[i];
                tick_d[i] = 1'b1;
                half_d[i] = shadow_q[i];
                pend_d[i] = 1'b0;
            end else begin
                cnt_d[i]  = cnt_q[i] + One;
                tick_d[i] = 1'b0;
            end
            // A write lands after the boundary load, so it waits for the next one.
            if (wr_hit && (32'(wr_ch) == i)) begin
                shadow_d[i] = wr_data;
                pend_d[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                half_q[i]   <= DefaultHalf;
                shadow_q[i] <= DefaultHalf;
            end
            out_q  <= '0;
            tick_q <= '0;
            pend_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
        end
    end

    assign divided_clk = out_q;
    assign tick        = tick_q;
    assign pending     = pend_q;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Bench for clk_divider_multi: directed scenarios with hand-derived traces plus
// randomized traffic checked against a per-channel elapsed-time model.
module tb_clk_divider_multi;

    localparam int unsigned NUM_CH       = 4;
    localparam int unsigned WIDTH        = 32;
    localparam int unsigned DEFAULT_HALF = 100_000_000;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] en;
    logic              wr_en;
    logic [3:0]        wr_ch;
    logic [WIDTH-1:0]  wr_data;
    logic [NUM_CH-1:0] divided_clk;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: elapsed cycles in the current half-period, active/staged period, output level.
    int unsigned       m_elapsed [NUM_CH];
    logic [WIDTH-1:0]  m_period  [NUM_CH];
    logic [WIDTH-1:0]  m_staged  [NUM_CH];
    logic [NUM_CH-1:0] m_level;
    logic [NUM_CH-1:0] m_tick;
    logic [NUM_CH-1:0] m_pend;

    clk_divider_multi #(
        .NUM_CH      (NUM_CH),
        .WIDTH       (WIDTH),
        .DEFAULT_HALF(DEFAULT_HALF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .divided_clk(divided_clk),
        .tick       (tick),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic model_advance(input logic r, input logic [NUM_CH-1:0] e, input logic we,
                                 input logic [3:0] wc, input logic [WIDTH-1:0] wd);
        int unsigned h;
        logic [WIDTH-1:0] old_staged [NUM_CH];
        for (int i = 0; i < NUM_CH; i++) old_staged[i] = m_staged[i];
        if (!r) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_elapsed[i] = 0;
                m_period[i]  = WIDTH'(DEFAULT_HALF);
                m_staged[i]  = WIDTH'(DEFAULT_HALF);
            end
            m_level = '0;
            m_tick  = '0;
            m_pend  = '0;
            return;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            h = (m_period[i] == 0) ? 1 : int'(m_period[i]);
            if (!e[i]) begin
                m_elapsed[i] = 0;
                m_level[i]   = 1'b0;
                m_tick[i]    = 1'b0;
                m_period[i]  = old_staged[i];
                m_pend[i]    = 1'b0;
            end else if (m_elapsed[i] + 1 == h) begin
                m_elapsed[i] = 0;
                m_level[i]   = ~m_level[i];
                m_tick[i]    = 1'b1;
                m_period[i]  = old_staged[i];
                m_pend[i]    = 1'b0;
            end else begin
                m_elapsed[i] = m_elapsed[i] + 1;
                m_tick[i]    = 1'b0;
            end
        end
        if (we && int'(wc) < NUM_CH) begin
            m_staged[wc] = wd;
            m_pend[wc]   = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic [NUM_CH-1:0] e, input logic we,
                        input logic [3:0] wc, input logic [WIDTH-1:0] wd);
        reset   = r;
        en      = e;
        wr_en   = we;
        wr_ch   = wc;
        wr_data = wd;
        model_advance(r, e, we, wc, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) step(1'b0, '1, 1'b0, 4'd0, '0);
        step(1'b1, '0, 1'b0, 4'd0, '0);
        n_tests++;
        if (divided_clk !== '0 || tick !== '0 || pending !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got clk=%b tick=%b pend=%b, want all 0",
                     divided_clk, tick, pending);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            n_tests++;
            if (dut.half_q[i] !== WIDTH'(DEFAULT_HALF)) begin
                n_fail++;
                $display("FAIL reset_half ch%0d: got %0d want %0d", i, dut.half_q[i],
                         DEFAULT_HALF);
            end
        end
    endtask

    task automatic test_ch0_half3();
        logic lvl;
        logic tk;
        step(1'b1, '0, 1'b1, 4'd0, 32'd3);
        n_tests++;
        if (pending !== 4'b0001) begin
            n_fail++;
            $display("FAIL ch0_pend_set: got %b want 0001", pending);
        end
        step(1'b1, '0, 1'b0, 4'd0, '0);
        n_tests++;
        if (pending !== 4'b0000 || dut.half_q[0] !== 32'd3) begin
            n_fail++;
            $display("FAIL ch0_pend_clear: got pend=%b half=%0d want 0000/3", pending,
                     dut.half_q[0]);
        end
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 4'b0001, 1'b0, 4'd0, '0);
            lvl = ((k / 3) % 2) == 1;
            tk  = (k % 3) == 0;
            n_tests++;
            if (divided_clk !== {3'b000, lvl} || tick !== {3'b000, tk}) begin
                n_fail++;
                $display("FAIL ch0_trace k=%0d: got clk=%b tick=%b want clk=%b tick=%b", k,
                         divided_clk, tick, {3'b000, lvl}, {3'b000, tk});
            end
        end
    endtask

    task automatic test_ch1_midwrite();
        logic lvl = 1'b0;
        logic tk;
        logic pd;
        step(1'b1, '0, 1'b1, 4'd1, 32'd4);
        step(1'b1, '0, 1'b0, 4'd0, '0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 4'b0010, k == 2, 4'd1, 32'd2);
            tk = (k == 4) || (k == 6) || (k == 8);
            if (tk) lvl = ~lvl;
            pd = (k >= 2) && (k < 4);
            n_tests++;
            if (divided_clk !== {2'b00, lvl, 1'b0} || tick !== {2'b00, tk, 1'b0} ||
                pending !== {2'b00, pd, 1'b0}) begin
                n_fail++;
                $display("FAIL ch1_trace k=%0d: got clk=%b tick=%b pend=%b want %b/%b/%b", k,
                         divided_clk, tick, pending, {2'b00, lvl, 1'b0}, {2'b00, tk, 1'b0},
                         {2'b00, pd, 1'b0});
            end
        end
    endtask

    task automatic test_ch2_wrap_write();
        logic lvl = 1'b0;
        logic tk;
        logic pd;
        step(1'b1, '0, 1'b1, 4'd2, 32'd2);
        step(1'b1, '0, 1'b0, 4'd0, '0);
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 4'b0100, k == 4, 4'd2, 32'd5);
            tk = (k == 2) || (k == 4) || (k == 6) || (k == 11);
            if (tk) lvl = ~lvl;
            pd = (k >= 4) && (k < 6);
            n_tests++;
            if (divided_clk !== {1'b0, lvl, 2'b00} || tick !== {1'b0, tk, 2'b00} ||
                pending !== {1'b0, pd, 2'b00}) begin
                n_fail++;
                $display("FAIL ch2_trace k=%0d: got clk=%b tick=%b pend=%b want %b/%b/%b", k,
                         divided_clk, tick, pending, {1'b0, lvl, 2'b00}, {1'b0, tk, 2'b00},
                         {1'b0, pd, 2'b00});
            end
        end
    endtask

    task automatic test_ch3_half0();
        logic lvl;
        step(1'b1, '0, 1'b1, 4'd3, 32'd0);
        step(1'b1, '0, 1'b0, 4'd0, '0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 4'b1000, 1'b0, 4'd0, '0);
            lvl = (k % 2) == 1;
            n_tests++;
            if (divided_clk !== {lvl, 3'b000} || tick !== 4'b1000 || pending !== 4'b0000) begin
                n_fail++;
                $display("FAIL ch3_trace k=%0d: got clk=%b tick=%b pend=%b want %b/1000/0000",
                         k, divided_clk, tick, pending, {lvl, 3'b000});
            end
        end
    endtask

    task automatic test_reset_mid_and_bad_write();
        for (int k = 0; k < 5; k++) step(1'b1, 4'b1111, k == 1, 4'd0, 32'd6);
        step(1'b0, 4'b1111, 1'b1, 4'd0, 32'd9);
        n_tests++;
        if (divided_clk !== '0 || tick !== '0 || pending !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got clk=%b tick=%b pend=%b want all 0", divided_clk,
                     tick, pending);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            n_tests++;
            if (dut.shadow_q[i] !== WIDTH'(DEFAULT_HALF) || dut.cnt_q[i] !== '0) begin
                n_fail++;
                $display("FAIL reset_mid_state ch%0d: got shadow=%0d cnt=%0d want %0d/0", i,
                         dut.shadow_q[i], dut.cnt_q[i], DEFAULT_HALF);
            end
        end
        step(1'b1, '0, 1'b1, 4'(NUM_CH), 32'd7);
        n_tests++;
        if (pending !== '0) begin
            n_fail++;
            $display("FAIL bad_write_pend: got %b want 0000", pending);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            n_tests++;
            if (dut.shadow_q[i] !== WIDTH'(DEFAULT_HALF)) begin
                n_fail++;
                $display("FAIL bad_write_shadow ch%0d: got %0d want %0d", i, dut.shadow_q[i],
                         DEFAULT_HALF);
            end
        end
    endtask

    task automatic test_random();
        logic              r;
        logic [NUM_CH-1:0] e;
        for (int i = 0; i < NUM_CH; i++) step(1'b1, '0, 1'b1, 4'(i), WIDTH'($urandom_range(0, 4)));
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 99) != 0);
            e = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '1;
            step(r, e, 1'($urandom), 4'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 5)));
            n_tests++;
            if (divided_clk !== m_level || tick !== m_tick || pending !== m_pend) begin
                n_fail++;
                $display("FAIL random k=%0d: got clk=%b tick=%b pend=%b want %b/%b/%b", k,
                         divided_clk, tick, pending, m_level, m_tick, m_pend);
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        en      = '0;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_data = '0;
        model_advance(1'b0, '0, 1'b0, 4'd0, '0);
        test_reset();
        test_ch0_half3();
        test_ch1_midwrite();
        test_ch2_wrap_write();
        test_ch3_half0();
        test_reset_mid_and_bad_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
- Parametrised successor to the single fixed-ratio clock divider.
- Provides NUM_CH independent divided-clock channels from one system clock.
- Each channel has a runtime-programmable half-period, a per-channel enable and a one-cycle tick strobe.
- Ratio changes are glitch-free: a new value is staged in a shadow register and applied only at a period boundary. Feeds LED/seven-segment scan, single-step and slow-clock logic in the pipeline CPU top level.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- WIDTH, 32, width of the half-period counter and divide registers.
- DEFAULT_HALF, 100_000_000, half-period loaded into every channel at reset.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- en  in  NUM_CH  per-channel enable, bit i drives channel i.
- wr_en  in  1  write strobe for the half-period shadow register.
- wr_ch  in  4  channel index for the write.
- wr_data  in  WIDTH  new half-period, in clk cycles.
- divided_clk  out  NUM_CH  per-channel divided clock, 50% duty.
- tick  out  NUM_CH  one-cycle pulse on every divided_clk toggle.
- pending  out  NUM_CH  shadow value written but not yet applied.

Behaviour:
- Per-channel state: cnt[WIDTH], half[WIDTH] (active), shadow[WIDTH], out bit, tick bit, pending bit.
- Reset (reset=0 at a rising clk):
  - cnt=0, half=shadow=DEFAULT_HALF, divided_clk=0, tick=0, pending=0 on all channels.
  - Reset takes priority over every other input, including mid-period.
- Effective half-period is H = max(half,1); a half value of 0 is treated as 1.
- Enabled channel (en[i]=1):
  - If cnt == H-1: cnt<=0, divided_clk[i] toggles, tick[i]<=1, half<=shadow, pending<=0.
  - Otherwise: cnt<=cnt+1, tick[i]<=0.
  - Output period is 2*H clk cycles, high H and low H.
  - tick is registered and asserts in the same cycle divided_clk changes.
- Disabled channel (en[i]=0):
  - cnt<=0, divided_clk[i]<=0, tick[i]<=0.
  - half<=shadow and pending<=0, so a stopped channel picks up the new value immediately.
- Enable rise: the first toggle (0->1) occurs H cycles after the first cycle en=1 is sampled.
- Write: when wr_en=1 and wr_ch<NUM_CH, shadow[wr_ch]<=wr_data and pending[wr_ch]<=1 on the next edge.
  - Writes with wr_ch>=NUM_CH are ignored, with no state change.
- Write in the same cycle as that channel's wrap:
  - The wrap loads the old shadow into half.
  - The new wr_data lands in shadow and pending stays 1.
  - The new value applies at the following wrap.
- Write in the same cycle as en=0 on that channel: shadow takes wr_data; half loads wr_data on the next edge while disabled.
- Multiple writes before a wrap: the last one wins.
- Channels are fully independent; there is no phase alignment between channels.
- Counter never exceeds H-1; there is no wrap-around overflow path.
- Outputs are driven straight from flops, with no combinational path from inputs to outputs.

Test Plan:
- Apply reset=0 for 3 cycles, then release with en=0 -> divided_clk=0, tick=0, pending=0 on all channels; internal half=DEFAULT_HALF.
- Write half=3 to ch0 while disabled, then set en[0]=1 -> ch0 rises 3 cycles after enable, period is 6 cycles (3 high/3 low), one tick on each edge, pending returns to 0 one cycle after the write.
- Ch1 running with half=4; write 2 mid-period at cnt=1 -> pending[1]=1, current half-period finishes at 4 cycles, subsequent half-periods are 2 cycles, pending clears at that wrap.
- Write 5 to ch2 exactly on its wrap cycle (running half=2) -> the next half-period is still 2 and only the one after is 5; pending[2] stays 1 until the second wrap.
- Write half=0 to ch3 and enable -> divided_clk[3] toggles every cycle (period 2) and tick[3] stays high continuously.
- Assert reset=0 mid-period on all channels, and separately issue wr_ch=NUM_CH with wr_data=7 -> all outputs return to reset values on the next edge; the out-of-range write changes no channel and no pending bit.
